// File: rtl/fetch_next_pc_pkg.sv
// Shared ISA definitions for the fetch stage: opcodes, instruction field
// positions and architectural register numbers.
package fetch_next_pc_pkg;

  typedef enum logic [4:0] {
    OPCODE_ALU  = 5'b00000,
    OPCODE_J    = 5'b00001,
    OPCODE_BNE  = 5'b00010,
    OPCODE_JAL  = 5'b00011,
    OPCODE_JR   = 5'b00100,
    OPCODE_ADDI = 5'b00101,
    OPCODE_BLT  = 5'b00110,
    OPCODE_SW   = 5'b00111,
    OPCODE_LW   = 5'b01000,
    OPCODE_SETX = 5'b10101,
    OPCODE_BEX  = 5'b10110
  } opcode_e;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 27;
  localparam int T_MSB       = 26;
  localparam int N_MSB       = 16;
  localparam int REG_RA      = 31;
  localparam int REG_RSTATUS = 30;

  // Branch offset field sign-extended to a full word.
  function automatic logic [31:0] sext_n(input logic [31:0] instr);
    return {{(31 - N_MSB){instr[N_MSB]}}, instr[N_MSB:0]};
  endfunction

endpackage

// File: rtl/fetch_next_pc_if.sv
// Fetch-stage bus: instruction memory port plus the decoder-facing
// instruction/control signals.
interface fetch_next_pc_if #(
  parameter int PC_WIDTH = 12
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_q;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic [PC_WIDTH-1:0] pc_plus_one;
  logic                instr_valid;
  logic                ctrl_J;
  logic                ctrl_Jal;
  logic                ctrl_Jr;
  logic                ctrl_bex;
  logic                ctrl_bne;
  logic                ctrl_blt;
  logic                cond_ne;
  logic                cond_lt;
  logic                rstatus_nz;
  logic [31:0]         jr_target;

  modport master (
    output imem_addr, instr, instr_pc, pc_plus_one, instr_valid,
    input  imem_q, ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bex, ctrl_bne, ctrl_blt,
           cond_ne, cond_lt, rstatus_nz, jr_target
  );

  modport slave (
    input  imem_addr, instr, instr_pc, pc_plus_one, instr_valid,
    output imem_q, ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bex, ctrl_bne, ctrl_blt,
           cond_ne, cond_lt, rstatus_nz, jr_target
  );
endinterface

// File: rtl/fetch_next_pc_next_pc_sel.sv
// Redirect decision and target selection for the instruction currently
// presented to the decoder.
module next_pc_sel
  import fetch_next_pc_pkg::*;
#(
  parameter int PC_WIDTH = 12
) (
  input  logic                accept,
  input  logic [31:0]         instr,
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                ctrl_J,
  input  logic                ctrl_Jal,
  input  logic                ctrl_Jr,
  input  logic                ctrl_bex,
  input  logic                ctrl_bne,
  input  logic                ctrl_blt,
  input  logic                cond_ne,
  input  logic                cond_lt,
  input  logic                rstatus_nz,
  input  logic [31:0]         jr_target,
  output logic [PC_WIDTH-1:0] target,
  output logic                redirect
);

  logic [31:0]         n_sext;
  logic [PC_WIDTH-1:0] t_target;
  logic [PC_WIDTH-1:0] bt_target;
  logic                jump_taken;
  logic                branch_taken;
  logic                unused_bits;

  always_comb begin
    n_sext       = sext_n(instr);
    t_target     = instr[PC_WIDTH-1:0];
    bt_target    = instr_pc + PC_WIDTH'(1) + n_sext[PC_WIDTH-1:0];
    jump_taken   = ctrl_J | ctrl_Jal | (ctrl_bex & rstatus_nz);
    branch_taken = (ctrl_bne & cond_ne) | (ctrl_blt & cond_lt);
    redirect     = accept & (ctrl_Jr | jump_taken | branch_taken);
    // Priority resolves non-one-hot controls: jr, then absolute, then relative.
    if (ctrl_Jr)         target = jr_target[PC_WIDTH-1:0];
    else if (jump_taken) target = t_target;
    else                 target = bt_target;
  end

  assign unused_bits = ^{jr_target[31:PC_WIDTH], n_sext[31:PC_WIDTH]};

endmodule

// File: rtl/fetch_next_pc.sv
// Fetch stage: owns the PC, drives the registered-read instruction memory
// and counts retired instructions.
module fetch_next_pc
  import fetch_next_pc_pkg::*;
#(
  parameter int                  PC_WIDTH  = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  fetch_next_pc_if.master      bus,
  output logic [CNT_WIDTH-1:0] retired_count
);

  logic [PC_WIDTH-1:0]  pc_q;
  logic [PC_WIDTH-1:0]  cur_pc_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PC_WIDTH-1:0]  target;
  logic                 redirect;
  logic                 accept;
  logic                 hold;

  assign accept = valid_q & ~stall;
  assign hold   = valid_q & stall;

  next_pc_sel #(.PC_WIDTH(PC_WIDTH)) u_sel (
    .accept     (accept),
    .instr      (bus.imem_q),
    .instr_pc   (cur_pc_q),
    .ctrl_J     (bus.ctrl_J),
    .ctrl_Jal   (bus.ctrl_Jal),
    .ctrl_Jr    (bus.ctrl_Jr),
    .ctrl_bex   (bus.ctrl_bex),
    .ctrl_bne   (bus.ctrl_bne),
    .ctrl_blt   (bus.ctrl_blt),
    .cond_ne    (bus.cond_ne),
    .cond_lt    (bus.cond_lt),
    .rstatus_nz (bus.rstatus_nz),
    .jr_target  (bus.jr_target),
    .target     (target),
    .redirect   (redirect)
  );

  // Address the target directly so a taken redirect costs no bubble; a stall
  // re-reads the current PC so imem_q stays put.
  always_comb begin
    bus.imem_addr = pc_q;
    if (reset)         bus.imem_addr = RESET_PC;
    else if (redirect) bus.imem_addr = target;
    else if (hold)     bus.imem_addr = cur_pc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      cur_pc_q <= RESET_PC;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (redirect) begin
        cur_pc_q <= target;
        pc_q     <= target + PC_WIDTH'(1);
        valid_q  <= 1'b1;
      end else if (!hold) begin
        cur_pc_q <= pc_q;
        pc_q     <= pc_q + PC_WIDTH'(1);
        valid_q  <= 1'b1;
      end
      if (accept) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.instr       = bus.imem_q;
  assign bus.instr_pc    = cur_pc_q;
  assign bus.pc_plus_one = cur_pc_q + PC_WIDTH'(1);
  assign bus.instr_valid = valid_q;
  assign retired_count   = cnt_q;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Directed bench for fetch_next_pc: registered-read imem model, a minimal
// opcode decoder, and a linear program walking jumps, branches, stalls and wrap.
module tb_fetch_next_pc;
  import fetch_next_pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] retired_count;
  logic [31:0] mem [0:4095];
  logic [4:0]  opc;
  int          n_checks = 0;
  int          n_fails  = 0;

  fetch_next_pc_if #(.PC_WIDTH(12)) bus ();

  fetch_next_pc #(.PC_WIDTH(12), .RESET_PC(12'd0), .CNT_WIDTH(32)) dut (
    .clock         (clk),
    .reset         (reset),
    .stall         (stall),
    .bus           (bus),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_q <= mem[bus.imem_addr];

  assign opc          = bus.instr[31:27];
  assign bus.ctrl_J   = (opc == OPCODE_J);
  assign bus.ctrl_Jal = (opc == OPCODE_JAL);
  assign bus.ctrl_Jr  = (opc == OPCODE_JR);
  assign bus.ctrl_bex = (opc == OPCODE_BEX);
  assign bus.ctrl_bne = (opc == OPCODE_BNE);
  assign bus.ctrl_blt = (opc == OPCODE_BLT);

  function automatic logic [31:0] enc_t(input opcode_e op, input int t);
    logic [31:0] tv;
    tv = t;
    return {op, tv[26:0]};
  endfunction

  function automatic logic [31:0] enc_n(input opcode_e op, input int n);
    logic [31:0] nv;
    nv = n;
    return {op, 10'b0, nv[16:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic check_at(input string tag, input int pc, input int cnt);
    logic [11:0] pcv;
    pcv = pc[11:0];
    chk({tag, ".valid"}, {31'b0, bus.instr_valid}, 32'd1);
    chk({tag, ".pc"}, {20'b0, bus.instr_pc}, {20'b0, pcv});
    chk({tag, ".instr"}, bus.instr, mem[pcv]);
    chk({tag, ".cnt"}, retired_count, cnt);
  endtask

  task automatic check_addr(input string tag, input int addr);
    logic [11:0] av;
    av = addr[11:0];
    #1;
    chk({tag, ".addr"}, {20'b0, bus.imem_addr}, {20'b0, av});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {OPCODE_ALU, 27'd0};
    mem[5]     = enc_t(OPCODE_J, 100);
    mem[7]     = enc_t(OPCODE_JAL, 200);
    mem[10]    = enc_n(OPCODE_BNE, -4);
    mem[11]    = enc_t(OPCODE_J, 20);
    mem[20]    = enc_n(OPCODE_BLT, 3);
    mem[24]    = {OPCODE_JR, 27'd0};
    mem[50]    = enc_n(OPCODE_BNE, 5);
    mem[56]    = enc_t(OPCODE_J, 4094);
    mem[101]   = enc_t(OPCODE_J, 7);
    mem[201]   = enc_t(OPCODE_J, 10);
    mem[12'hABC] = enc_t(OPCODE_BEX, 50);
    mem[12'hABD] = enc_t(OPCODE_BEX, 50);

    reset = 1'b1;
    stall = 1'b0;
    bus.cond_ne    = 1'b0;
    bus.cond_lt    = 1'b0;
    bus.rstatus_nz = 1'b0;
    bus.jr_target  = 32'd0;

    adv(); adv();
    chk("rst.valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst.cnt", retired_count, 32'd0);
    chk("rst.addr", {20'b0, bus.imem_addr}, 32'd0);

    reset = 1'b0;
    check_addr("bubble", 0);
    chk("bubble.valid", {31'b0, bus.instr_valid}, 32'd0);

    adv(); check_at("seq0", 0, 0);
    adv(); check_at("seq1", 1, 1);
    adv(); check_at("seq2", 2, 2);

    stall = 1'b1;
    check_addr("stall", 2);
    for (int i = 0; i < 3; i++) begin
      adv();
      check_at("stall_hold", 2, 2);
      chk("stall_hold.addr", {20'b0, bus.imem_addr}, 32'd2);
    end
    stall = 1'b0;
    check_addr("unstall", 3);
    adv(); check_at("seq3", 3, 3);
    adv(); check_at("seq4", 4, 4);
    adv(); check_at("j_at5", 5, 5);
    check_addr("j_at5", 100);
    adv(); check_at("j_tgt", 100, 6);
    adv(); check_at("j_next", 101, 7);
    adv(); check_at("jal", 7, 8);
    chk("jal.ppo", {20'b0, bus.pc_plus_one}, 32'd8);
    check_addr("jal", 200);
    adv(); check_at("jal_tgt", 200, 9);
    adv(); check_at("j10", 201, 10);
    adv(); check_at("bne1", 10, 11);

    bus.cond_ne = 1'b1;
    check_addr("bne_taken", 7);
    adv(); check_at("bne_tgt", 7, 12);
    bus.cond_ne = 1'b0;
    adv(); check_at("jal2", 200, 13);
    adv(); check_at("j10b", 201, 14);
    adv(); check_at("bne2", 10, 15);
    check_addr("bne_nt", 11);
    adv(); check_at("bne_fall", 11, 16);
    adv(); check_at("blt", 20, 17);

    bus.cond_lt = 1'b1;
    check_addr("blt_taken", 24);
    adv(); check_at("blt_tgt", 24, 18);
    bus.cond_lt   = 1'b0;
    bus.jr_target = 32'h0000_1ABC;
    check_addr("jr", 12'hABC);
    adv(); check_at("jr_tgt", 12'hABC, 19);
    bus.jr_target = 32'd0;
    check_addr("bex_nt", 12'hABD);
    adv(); check_at("bex_fall", 12'hABD, 20);

    bus.rstatus_nz = 1'b1;
    check_addr("bex_taken", 50);
    adv(); check_at("bex_tgt", 50, 21);
    bus.rstatus_nz = 1'b0;

    bus.cond_ne = 1'b1;
    stall       = 1'b1;
    check_addr("br_stall", 50);
    adv(); check_at("br_stall1", 50, 21);
    adv(); check_at("br_stall2", 50, 21);
    stall = 1'b0;
    check_addr("br_release", 56);
    adv(); check_at("br_tgt", 56, 22);
    bus.cond_ne = 1'b0;

    adv(); check_at("pre_wrap", 4094, 23);
    adv(); check_at("top_pc", 4095, 24);
    check_addr("wrap", 0);
    adv(); check_at("wrapped", 0, 25);
    adv(); check_at("w1", 1, 26);
    adv(); check_at("w2", 2, 27);
    adv(); check_at("w3", 3, 28);
    adv(); check_at("w4", 4, 29);
    adv(); check_at("w5_j", 5, 30);

    reset = 1'b1;
    check_addr("mid_rst", 0);
    adv();
    chk("mid_rst.valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("mid_rst.cnt", retired_count, 32'd0);
    chk("mid_rst.pc", {20'b0, bus.instr_pc}, 32'd0);
    reset = 1'b0;
    check_addr("mid_rst_bubble", 0);
    adv(); check_at("restart0", 0, 0);
    adv(); check_at("restart1", 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
